// File: rtl/ecc_codeword_checker.sv
// -----------------------------------------------------------------------------
// ecc_codeword_checker
//
// Purpose
//   Registered read-path checker that sits between a memory read port and the
//   data consumer. Each 12-bit stored codeword {data[7:0], parity[3:0]} has its
//   four parity bits recomputed. The data is forwarded unmodified, together
//   with an error flag and the syndrome, over a valid/ready stream with a
//   single output register (1-cycle latency, 1 word/cycle throughput).
//   A saturating error counter and a sticky first-error address log support
//   software scrubbing.
//
// Optional feature
//   ECC_THRESH_IRQ_EN : when defined, adds a registered, sticky irq output that
//                       rises once err_count reaches IRQ_THRESH.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  input handshake; in_code = {data, parity}, in_addr = tag
//   out_valid/ready output handshake; out_data, out_err, out_syndrome, out_addr
//   clr             synchronous clear of err_count and the first-error log
//   err_count       saturating count of accepted erroneous words
//   first_err_vld   sticky flag: an error has been logged
//   first_err_addr  address tag of the first logged error
//   irq             threshold interrupt (ECC_THRESH_IRQ_EN only)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module ecc_codeword_checker #(
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = 8,
  parameter int IRQ_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [11:0]       in_code,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_err,
  output logic [3:0]        out_syndrome,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              clr,
  output logic [CNT_W-1:0]  err_count,
  output logic              first_err_vld,
  output logic [ADDR_W-1:0] first_err_addr
`ifdef ECC_THRESH_IRQ_EN
  ,
  output logic              irq
`endif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Output stage state and payload registers
  state_e              state_q, state_d;
  logic [7:0]          data_q;
  logic                err_q;
  logic [3:0]          syn_q;
  logic [ADDR_W-1:0]   addr_q;

  // Error bookkeeping
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic                first_vld_q, first_vld_d;
  logic [ADDR_W-1:0]   first_addr_q, first_addr_d;

  // Syndrome of the incoming codeword
  logic [7:0]          d;
  logic [3:0]          p;
  logic [3:0]          syndrome;
  logic                code_err;
  logic                accept;

  assign d = in_code[11:4];
  assign p = in_code[3:0];

  assign syndrome[0] = p[0] ^ d[0] ^ d[1] ^ d[2];
  assign syndrome[1] = p[1] ^ d[1] ^ d[3] ^ d[4];
  assign syndrome[2] = p[2] ^ d[2] ^ d[5] ^ d[6];
  assign syndrome[3] = p[3] ^ d[3] ^ d[6] ^ d[7];
  assign code_err    = |syndrome;

  // The register can take a new word when empty, or when its current word
  // leaves in the same cycle.
  assign in_ready = (state_q == ST_EMPTY) | out_ready;
  assign accept   = in_valid & in_ready;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path can leave it unassigned, which would infer a latch.
  always_comb begin
    state_d      = state_q;
    err_count_d  = clr ? '0 : err_count_q;
    first_vld_d  = clr ? 1'b0 : first_vld_q;
    first_addr_d = clr ? '0 : first_addr_q;

    if (accept) begin
      state_d = ST_FULL;
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end

    // The clear is folded in before the increment, so clr together with an
    // erroneous accept leaves a count of one and logs the new address.
    if (accept && code_err) begin
      if (err_count_d != CNT_MAX) begin
        err_count_d = err_count_d + CNT_W'(1);
      end
      if (!first_vld_d) begin
        first_vld_d  = 1'b1;
        first_addr_d = in_addr;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      err_q        <= 1'b0;
      syn_q        <= '0;
      addr_q       <= '0;
      err_count_q  <= '0;
      first_vld_q  <= 1'b0;
      first_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      err_count_q  <= err_count_d;
      first_vld_q  <= first_vld_d;
      first_addr_q <= first_addr_d;
      // Payload only changes on accept, so it holds under backpressure.
      if (accept) begin
        data_q <= d;
        err_q  <= code_err;
        syn_q  <= syndrome;
        addr_q <= in_addr;
      end
    end
  end

  assign out_valid      = (state_q == ST_FULL);
  assign out_data       = data_q;
  assign out_err        = err_q;
  assign out_syndrome   = syn_q;
  assign out_addr       = addr_q;
  assign err_count      = err_count_q;
  assign first_err_vld  = first_vld_q;
  assign first_err_addr = first_addr_q;

`ifdef ECC_THRESH_IRQ_EN
  localparam logic [31:0] IRQ_THRESH_U = IRQ_THRESH;

  logic irq_q;

  // Sticky once the threshold is reached; clr wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else if (clr) begin
      irq_q <= 1'b0;
    end else if (32'(err_count_d) >= IRQ_THRESH_U) begin
      irq_q <= 1'b1;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_thresh;
  assign unused_irq_thresh = ^IRQ_THRESH;
`endif

endmodule

// File: tb/tb_ecc_codeword_checker.sv
`timescale 1ns/1ps

module tb_ecc_codeword_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // Main instance (CNT_W = 8)
  logic        in_valid, in_ready, out_valid, out_ready, clr;
  logic [11:0] in_code;
  logic [7:0]  in_addr, out_data, out_addr, err_count, first_err_addr;
  logic        out_err, first_err_vld;
  logic [3:0]  out_syndrome;
  // Saturation instance (CNT_W = 2)
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_clr;
  logic [11:0] s_in_code;
  logic [7:0]  s_in_addr, s_out_data, s_out_addr, s_first_err_addr;
  logic [1:0]  s_err_count;
  logic        s_out_err, s_first_err_vld;
  logic [3:0]  s_out_syndrome;
`ifdef ECC_THRESH_IRQ_EN
  logic        irq, s_irq;
`endif

  ecc_codeword_checker #(.ADDR_W(8), .CNT_W(8), .IRQ_THRESH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .out_syndrome(out_syndrome), .out_addr(out_addr),
    .clr(clr), .err_count(err_count), .first_err_vld(first_err_vld),
    .first_err_addr(first_err_addr)
`ifdef ECC_THRESH_IRQ_EN
    , .irq(irq)
`endif
  );

  ecc_codeword_checker #(.ADDR_W(8), .CNT_W(2), .IRQ_THRESH(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_code(s_in_code), .in_addr(s_in_addr),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_err(s_out_err), .out_syndrome(s_out_syndrome), .out_addr(s_out_addr),
    .clr(s_clr), .err_count(s_err_count), .first_err_vld(s_first_err_vld),
    .first_err_addr(s_first_err_addr)
`ifdef ECC_THRESH_IRQ_EN
    , .irq(s_irq)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference syndrome: each check bit is the parity of the stored parity bit
  // and the data bits selected by its row of the parity-check matrix.
  function automatic logic [3:0] ref_syn(input logic [11:0] code);
    logic [7:0] rows [4];
    logic [3:0] s;
    rows = '{8'h07, 8'h1A, 8'h64, 8'hC8};
    for (int j = 0; j < 4; j++) s[j] = (^(code[11:4] & rows[j])) ^ code[j];
    return s;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [3:0] syn;
    logic [7:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_pushed = 0, n_popped = 0;

  // Abstract model of the main instance
  bit   m_full = 0, m_vld = 0, m_irq = 0;
  int   m_cnt  = 0;
  logic [7:0] m_addr = '0;

  // Predictor: compares architectural state each cycle, then applies the
  // coming edge using the sampled inputs.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full = 0; m_vld = 0; m_irq = 0; m_cnt = 0; m_addr = '0;
      sb.delete();
    end else begin
      bit         rdy, acc, err;
      logic [3:0] syn;
      int         nxt;
      check("out_valid", out_valid, m_full);
      check("in_ready", in_ready, !m_full || out_ready);
      check("err_count", err_count, m_cnt);
      check("first_err_vld", first_err_vld, m_vld);
      check("first_err_addr", first_err_addr, m_addr);
`ifdef ECC_THRESH_IRQ_EN
      check("irq", irq, m_irq);
`endif
      rdy = !m_full || out_ready;
      acc = in_valid && rdy;
      syn = ref_syn(in_code);
      err = (syn != 0);
      if (acc) begin
        sb.push_back('{data: in_code[11:4], err: err, syn: syn, addr: in_addr});
        n_pushed++;
      end
      nxt = (clr ? 0 : m_cnt) + ((acc && err) ? 1 : 0);
      if (nxt > 255) nxt = 255;
      if (clr) begin m_vld = 0; m_addr = '0; end
      if (acc && err && !m_vld) begin m_vld = 1; m_addr = in_addr; end
      if (clr) m_irq = 0;
      else if (nxt >= 4) m_irq = 1;
      m_cnt  = nxt;
      m_full = acc ? 1'b1 : (out_ready ? 1'b0 : m_full);
    end
  end

  // Monitor: every word the consumer takes is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: word 0x%0h delivered, none expected", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_popped++;
        check("out_data", out_data, e.data);
        check("out_err", out_err, e.err);
        check("out_syndrome", out_syndrome, e.syn);
        check("out_addr", out_addr, e.addr);
      end
    end
  end

  task automatic send(input logic [11:0] code, input logic [7:0] addr);
    bit ok = 0;
    in_valid = 1'b1;
    in_code  = code;
    in_addr  = addr;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: code 0x%0h not accepted", code);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !out_valid;
    end
    check("drain_done", done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 0; in_code = '0; in_addr = '0; out_ready = 0; clr = 0;
    s_in_valid = 0; s_in_code = '0; s_in_addr = '0; s_out_ready = 1; s_clr = 0;
    #23;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_err_count", err_count, 0);
    check("rst_first_vld", first_err_vld, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean words back to back
    out_ready = 1'b1;
    send(12'hAA5, 8'h01);
    check("t1_data0", out_data, 8'hAA);
    check("t1_err0", out_err, 0);
    send(12'hF02, 8'h02);
    check("t1_data1", out_data, 8'hF0);
    check("t1_err1", out_err, 0);
    drain();
    check("t1_cnt", err_count, 0);

    // Single-bit errors
    send(12'hAA4, 8'h10);
    check("t2_syn0", out_syndrome, 4'b0001);
    send(12'h2A5, 8'h11);
    check("t2_syn1", out_syndrome, 4'b1000);
    drain();
    check("t2_cnt", err_count, 2);
    check("t2_first_addr", first_err_addr, 8'h10);

    // Backpressure: second word waits while the first is held
    out_ready = 1'b0;
    send(12'h123, 8'h40);
    in_valid = 1'b1; in_code = 12'h456; in_addr = 8'h41;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_in_ready", in_ready, 0);
      check("t3_hold_data", out_data, 8'h12);
      check("t3_hold_addr", out_addr, 8'h40);
      check("t3_hold_syn", out_syndrome, ref_syn(12'h123));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    check("t3_no_loss", n_popped, n_pushed);

`ifdef ECC_THRESH_IRQ_EN
    // Threshold interrupt
    clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
    check("t6_irq_clr", irq, 0);
    for (int i = 0; i < 4; i++) begin
      send(12'hAA4, 8'h50 + 8'(i));
      check("t6_irq_level", irq, (i == 3) ? 1 : 0);
    end
    clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
    check("t6_irq_cleared", irq, 0);
    drain();
`endif

    // Randomized traffic with random backpressure and occasional clr
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit acc;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 49) == 0);
      if (!in_valid || acc) begin
        logic [7:0] dd;
        in_valid = ($urandom_range(0, 3) != 0);
        dd       = 8'($urandom);
        in_addr  = 8'($urandom);
        if ($urandom_range(0, 1) == 0) in_code = {dd, ref_syn({dd, 4'h0})};
        else                           in_code = 12'($urandom);
      end
    end
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0;
    drain();
    check("rand_no_loss", n_popped, n_pushed);

    // Asynchronous reset while the output register is full
    out_ready = 1'b0;
    send(12'hAA4, 8'h77);
    #3 rst_n = 1'b0;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_out_data", out_data, 0);
    check("t5_out_err", out_err, 0);
    check("t5_out_syn", out_syndrome, 0);
    check("t5_out_addr", out_addr, 0);
    check("t5_cnt", err_count, 0);
    check("t5_first_vld", first_err_vld, 0);
    check("t5_first_addr", first_err_addr, 0);
    check("t5_in_ready_rst", in_ready, 1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("t5_in_ready_after", in_ready, 1);
    @(posedge clk); #1;

    // Saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1; s_in_code = 12'hAA4; s_in_addr = 8'h20 + 8'(i);
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    @(negedge clk);
    check("t4_sat_cnt", s_err_count, 3);
    check("t4_first_addr", s_first_err_addr, 8'h20);
    check("t4_last_syn", s_out_syndrome, 4'b0001);
    @(posedge clk); #1;
    s_in_valid = 1'b1; s_in_code = 12'h2A5; s_in_addr = 8'h30; s_clr = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0; s_clr = 1'b0;
    @(negedge clk);
    check("t4_clr_cnt", s_err_count, 1);
    check("t4_clr_vld", s_first_err_vld, 1);
    check("t4_clr_addr", s_first_err_addr, 8'h30);
`ifdef ECC_THRESH_IRQ_EN
    check("t4_sat_irq", s_irq, 0);
`endif
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
